// File: rtl/core_dbus_wb_master_if.sv
// Wishbone B4 classic bus bundle between the data-bus bridge (master) and a memory/peripheral slave.
interface core_dbus_wb_master_if;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i, wb_err_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      output wb_dat_i, wb_ack_i, wb_err_i
   );
endinterface

// File: rtl/core_dbus_wb_master.sv
// RV32I MEM-stage load/store to single Wishbone cycle bridge with pipeline stall.
// Optional BUSY watchdog enabled by defining DBUS_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
//
// state | meaning
// IDLE  | waiting for a MEM-stage request
// BUSY  | Wishbone cycle in flight, outputs held until ack/err/timeout
// DONE  | one-cycle completion, result and error presented, pipeline released
module core_dbus_wb_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr_mem,
   input  logic [31:0] mem_wdata_mem,
   input  logic        mem_write_mem,
   input  logic        mem_read_mem,
   input  logic [2:0]  mem_op_mem,
   output logic [31:0] mem_rdata_mem,
   output logic        stall_pipl,
   output logic        bus_err,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;
   logic        we_q, we_d;
   logic        cyc_q, cyc_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [2:0]  op_q, op_d;
   logic [1:0]  lane_q, lane_d;

   logic        req;
   logic        illegal;
   logic [3:0]  req_sel;
   logic [31:0] req_dat;
   logic        tmo;

   always_comb begin
      req     = mem_read_mem | mem_write_mem;
      req_sel = 4'b0000;
      req_dat = mem_wdata_mem;
      illegal = 1'b0;
      case (mem_op_mem)
         3'b000, 3'b100: begin
            req_sel = 4'b0001 << mem_addr_mem[1:0];
            req_dat = {4{mem_wdata_mem[7:0]}};
         end
         3'b001, 3'b101: begin
            req_sel = mem_addr_mem[1] ? 4'b1100 : 4'b0011;
            req_dat = {2{mem_wdata_mem[15:0]}};
            illegal = mem_addr_mem[0];
         end
         3'b010: begin
            req_sel = 4'b1111;
            req_dat = mem_wdata_mem;
            illegal = |mem_addr_mem[1:0];
         end
         default: illegal = 1'b1;
      endcase
   end

   function automatic logic [31:0] fmt_load(input logic [31:0] d,
                                            input logic [2:0]  op,
                                            input logic [1:0]  lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = lane[1] ? d[31:16] : d[15:0];
      case (op)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'd0, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'd0, h};
         default: r = d;
      endcase
      return r;
   endfunction

`ifdef DBUS_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;

   // cnt_q counts BUSY cycles already elapsed, so the limit fires on the TIMEOUT_CYCLES-th one
   assign tmo = (state_q == S_BUSY) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= 16'd0;
      else       cnt_q <= cnt_d;
   end
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      we_d    = we_q;
      cyc_d   = cyc_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      op_d    = op_q;
      lane_d  = lane_q;
`ifdef DBUS_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req) begin
               op_d    = mem_op_mem;
               lane_d  = mem_addr_mem[1:0];
               rdata_d = 32'd0;
               if (illegal) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  adr_d   = {mem_addr_mem[31:2], 2'b00};
                  dat_d   = req_dat;
                  sel_d   = req_sel;
                  we_d    = mem_write_mem;
                  cyc_d   = 1'b1;
                  err_d   = 1'b0;
                  state_d = S_BUSY;
`ifdef DBUS_TIMEOUT_EN
                  cnt_d   = 16'd0;
`endif
               end
            end
         end
         S_BUSY: begin
`ifdef DBUS_TIMEOUT_EN
            cnt_d = cnt_q + 16'd1;
`endif
            if (wb_err_i) begin
               cyc_d   = 1'b0;
               err_d   = 1'b1;
               rdata_d = 32'd0;
               state_d = S_DONE;
            end else if (wb_ack_i) begin
               cyc_d   = 1'b0;
               err_d   = 1'b0;
               rdata_d = we_q ? 32'd0 : fmt_load(wb_dat_i, op_q, lane_q);
               state_d = S_DONE;
            end else if (tmo) begin
               cyc_d   = 1'b0;
               err_d   = 1'b1;
               rdata_d = 32'd0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         adr_q   <= 32'd0;
         dat_q   <= 32'd0;
         sel_q   <= 4'd0;
         we_q    <= 1'b0;
         cyc_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
         op_q    <= 3'd0;
         lane_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         cyc_q   <= cyc_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         op_q    <= op_d;
         lane_q  <= lane_d;
      end
   end

   // rdata_q/err_q are only non-zero while in DONE, so they drive the core directly
   assign mem_rdata_mem = rdata_q;
   assign bus_err       = err_q;
   assign stall_pipl    = ((state_q == S_IDLE) && req) || (state_q == S_BUSY);

   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = sel_q;
   assign wb_we_o  = we_q;
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;

endmodule

// File: doc/core_dbus_wb_master.md
# core_dbus_wb_master

Data-bus bridge between the RV32I core's memory-stage port and a classic single-cycle Wishbone B4 master interface. It converts each load/store presented by the MEM stage into one Wishbone cycle, with byte-lane selection, store-data replication and load sign/zero extension. It drives the core's `stall_pipl` input to freeze the pipeline until the access completes.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum BUSY cycles before forced termination. Used only with `DBUS_TIMEOUT_EN`. Range 1..65535.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_addr_mem`  in  32  byte address from the MEM stage.
- `mem_wdata_mem`  in  32  store data, LSB-aligned.
- `mem_write_mem`  in  1  store request.
- `mem_read_mem`  in  1  load request.
- `mem_op_mem`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `mem_rdata_mem`  out  32  formatted load data to the core.
- `stall_pipl`  out  1  pipeline freeze to the core.
- `bus_err`  out  1  one-cycle pulse when an access completes with an error.
- `wb_adr_o`  out  32  word address, `{addr[31:2],2'b00}`.
- `wb_dat_o`  out  32  replicated store data.
- `wb_sel_o`  out  4  byte-lane selects.
- `wb_we_o`, `wb_cyc_o`, `wb_stb_o`  out  1 each  Wishbone controls.
- `wb_dat_i`  in  32  slave read data.
- `wb_ack_i`, `wb_err_i`  in  1 each  slave termination.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE: a request is `mem_read_mem | mem_write_mem`. If both are asserted, the write wins.
- Legal request in IDLE: register `wb_adr_o`, `wb_dat_o`, `wb_sel_o` and `wb_we_o`; set `cyc`/`stb`; go to BUSY.
- Illegal request in IDLE goes straight to DONE with the error flag set and no bus cycle. Illegal means:
  - H/HU with `addr[0]=1`;
  - W with `addr[1:0]≠0`;
  - funct3 of 011, 110 or 111.
- BUSY holds all Wishbone outputs stable until termination.
  - `wb_err_i` ends the cycle with error; it has priority over a simultaneous `wb_ack_i`.
  - `wb_ack_i` ends the cycle with success. On a read, `wb_dat_i` is formatted and latched.
  - On either termination: drop `cyc`/`stb` and go to DONE.
- DONE lasts exactly one cycle, then returns to IDLE.
  - `mem_rdata_mem` presents the latched value; it is 0 on error or on a write.
  - `bus_err` is 1 if the access failed.
  - The pipeline advances at the end of this cycle.
- `stall_pipl` = (IDLE & request) | BUSY. It is combinational and is 0 in DONE.
- Store lanes:
  - SB: sel = `4'b0001<<addr[1:0]`; data = byte replicated ×4.
  - SH: sel = 0011 (`addr[1]=0`) or 1100; data = halfword replicated ×2.
  - SW: sel = 1111.
- Load format: select the byte or halfword lane by `addr[1:0]`.
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
- Load `wb_sel_o` uses the same lane rule as stores.
- Reset values: state IDLE; all Wishbone outputs 0; `mem_rdata_mem` 0; `bus_err` 0; `stall_pipl` 0.
- Reset asserted mid-cycle drops `cyc`/`stb` immediately (asynchronous). The interrupted access is abandoned, not replayed.

## Timing
- Request seen at cycle 0 with ack at cycle 1 (the earliest possible): DONE at cycle 2. The stall is high for cycles 0–1.
- Ack at cycle N: DONE at N+1. Minimum 3 cycles per access.
- Illegal access: IDLE at cycle 0, DONE at cycle 1, 1 stall cycle.
- Back-to-back accesses: at least one cycle with `cyc=0` (DONE) between cycles.
- Ack or err while in IDLE or DONE is ignored.

## Configuration
- `DBUS_TIMEOUT_EN` defined: a 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches `TIMEOUT_CYCLES` with no ack/err: drop `cyc`/`stb`, go to DONE with error (`rdata`=0, `bus_err`=1).
  - Ack or err on that same cycle takes precedence over the timeout.
- Macro undefined: no counter, and BUSY waits indefinitely.

## Test plan
- LB at `0x103` with `wb_dat_i=0x80FF_1234`, ack after 2 cycles -> `wb_sel_o=1000`, `wb_adr_o=0x100`, `mem_rdata_mem=0xFFFF_FF80` in DONE, stall high exactly 3 cycles.
- SH to `0x202`, data `0x0000_ABCD` -> `wb_sel_o=1100`, `wb_dat_o=0xABCD_ABCD`, `wb_we_o=1`; DONE `rdata=0`, `bus_err=0`.
- LW at `0x5` -> no `cyc` asserted; `bus_err=1` for one cycle, `rdata=0`, stall high 1 cycle.
- Read with `wb_ack_i` and `wb_err_i` asserted together -> error path taken, `bus_err=1`, `rdata=0`.
- `DBUS_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, slave never acks -> `cyc` drops after 4 BUSY cycles, `bus_err=1`; without the macro, stall stays high for 1000 cycles.
- Reset pulsed during BUSY -> `cyc`/`stb`/`stall_pipl` go 0 asynchronously; the next LHU at `0x10` with `0x0000_F00D` returns `0x0000_F00D`.
